// File: rtl/gpo_timed.sv
`default_nettype none
// ============================================================================
// Module   : gpo_timed
// Purpose  : General-purpose output core for an MMIO slot. Drives W output
//            bits from a processor-writable register. Supports atomic
//            set/clear/toggle and a hardware-timed one-shot pulse.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous reset, active low
//            cs       - chip select
//            read     - read strobe (no side effects)
//            write    - write strobe, qualified by cs
//            addr     - register index (0 DATA, 1 SET, 2 CLR, 3 TGL,
//                       4 PLEN, 5 PULSE, 6 STATUS)
//            wr_data  - write data
//            rd_data  - combinational read data
//            data_out - external outputs
// Revision : 1.0 - initial release
// ============================================================================
module gpo_timed #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [W-1:0]  data_out
);

  localparam logic [4:0] ADDR_DATA   = 5'd0;
  localparam logic [4:0] ADDR_SET    = 5'd1;
  localparam logic [4:0] ADDR_CLR    = 5'd2;
  localparam logic [4:0] ADDR_TGL    = 5'd3;
  localparam logic [4:0] ADDR_PLEN   = 5'd4;
  localparam logic [4:0] ADDR_PULSE  = 5'd5;
  localparam logic [4:0] ADDR_STATUS = 5'd6;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  out_reg, out_nxt;
  logic [15:0]   plen, plen_nxt;
  logic [W-1:0]  pmask, pmask_nxt;
  logic [15:0]   cnt, cnt_nxt;

  logic          wr_en;
  logic [W-1:0]  wr_mask;
  logic          busy;

  // Reads have no side effects and upper write bits are never stored.
  logic          unused_bits;
  assign unused_bits = ^{read, wr_data[31:16]};

  assign wr_en   = cs & write;
  assign wr_mask = wr_data[W-1:0];
  assign busy    = (state == ACTIVE);

  // State and register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      out_reg <= '0;
      plen    <= '0;
      pmask   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      out_reg <= out_nxt;
      plen    <= plen_nxt;
      pmask   <= pmask_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state logic. The bus write is evaluated first; the pulse expiry
  // clear is applied afterwards so pulse bits always end low even when a
  // write lands on the expiry edge.
  always_comb begin
    state_nxt = state;
    out_nxt   = out_reg;
    plen_nxt  = plen;
    pmask_nxt = pmask;
    cnt_nxt   = cnt;

    if (wr_en) begin
      case (addr)
        ADDR_DATA: out_nxt  = wr_mask;
        ADDR_SET:  out_nxt  = out_reg | wr_mask;
        ADDR_CLR:  out_nxt  = out_reg & ~wr_mask;
        ADDR_TGL:  out_nxt  = out_reg ^ wr_mask;
        ADDR_PLEN: plen_nxt = wr_data[15:0];
        ADDR_PULSE: begin
          // Only an idle FSM starts a pulse; zero length or empty mask is a no-op.
          if (state == IDLE && plen != 16'd0 && wr_mask != '0) begin
            state_nxt = ACTIVE;
            pmask_nxt = wr_mask;
            cnt_nxt   = plen;
            out_nxt   = out_reg | wr_mask;
          end
        end
        default: ;
      endcase
    end

    if (state == ACTIVE) begin
      if (cnt == 16'd1) begin
        out_nxt   = out_nxt & ~pmask;
        cnt_nxt   = 16'd0;
        pmask_nxt = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt - 16'd1;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    rd_data = 32'd0;
    case (addr)
      ADDR_DATA:   rd_data = {{(32-W){1'b0}}, out_reg};
      ADDR_PLEN:   rd_data = {16'd0, plen};
      ADDR_PULSE:  rd_data = {{(32-W){1'b0}}, pmask};
      ADDR_STATUS: rd_data = {cnt, 15'd0, busy};
      default:     rd_data = 32'd0;
    endcase
  end

  assign data_out = out_reg;

endmodule
`default_nettype wire

// File: tb/tb_gpo_timed.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpo_timed
// Purpose  : Self-checking bench for gpo_timed (W = 8). Directed scenarios
//            followed by randomized bus traffic, compared against a
//            behavioural model that tracks the pulse as an absolute end edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpo_timed;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic [7:0]  data_out;

  gpo_timed #(.W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model: the pulse is an interval of edges [start, m_end).
  int unsigned edge_no = 0;
  logic [7:0]  m_out   = 8'h00;
  logic [15:0] m_plen  = 16'h0000;
  logic [7:0]  m_pmask = 8'h00;
  bit          m_active = 1'b0;
  int unsigned m_end   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  function automatic void model_edge(input bit rst_n, input bit we,
                                     input logic [4:0] a, input logic [31:0] d);
    logic [7:0] nv;
    if (!rst_n) begin
      m_out = 8'h00; m_plen = 16'h0; m_pmask = 8'h00; m_active = 1'b0; m_end = 0;
      return;
    end
    nv = m_out;
    if (we) begin
      case (a)
        5'd0: nv = d[7:0];
        5'd1: nv = nv | d[7:0];
        5'd2: nv = nv & ~d[7:0];
        5'd3: nv = nv ^ d[7:0];
        5'd4: m_plen = d[15:0];
        5'd5: if (!m_active && m_plen != 0 && d[7:0] != 0) begin
          m_active = 1'b1;
          m_pmask  = d[7:0];
          m_end    = edge_no + m_plen;
          nv       = nv | d[7:0];
        end
        default: ;
      endcase
    end
    if (m_active && edge_no == m_end) begin
      nv       = nv & ~m_pmask;
      m_pmask  = 8'h00;
      m_active = 1'b0;
    end
    m_out = nv;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [15:0] rem;
    if (!m_active) return 32'h0;
    rem = 16'(m_end - edge_no);
    return {rem, 15'd0, 1'b1};
  endfunction

  // Compare every observable register against the model; ends at t+5.
  task automatic check_all();
    chk("data_out", {24'd0, data_out}, {24'd0, m_out});
    addr = 5'd0; #1; chk("rd_data", rd_data, {24'd0, m_out});
    addr = 5'd4; #1; chk("rd_plen", rd_data, {16'd0, m_plen});
    addr = 5'd5; #1; chk("rd_pmask", rd_data, {24'd0, m_pmask});
    addr = 5'd6; #1; chk("rd_status", rd_data, exp_status());
  endtask

  // One clock: drive bus, take the edge, update the model, check.
  task automatic step(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d);
    cs = c; write = w; addr = a; wr_data = d; read = ~w & c;
    @(posedge clk);
    edge_no++;
    model_edge(reset, c & w, a, d);
    #1;
    cs = 1'b0; write = 1'b0; read = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset held for two cycles.
    reset = 1'b0;
    idle();
    idle();
    chk("rst_data_out", {24'd0, data_out}, 32'h0);
    reset = 1'b1;

    // Basic write and atomic ops.
    wr(5'd0, 32'h0000_00A5); chk("data_a5", {24'd0, data_out}, 32'hA5);
    wr(5'd1, 32'h0000_000F); chk("set_af",  {24'd0, data_out}, 32'hAF);
    wr(5'd2, 32'h0000_0081); chk("clr_2e",  {24'd0, data_out}, 32'h2E);
    wr(5'd3, 32'h0000_00FF); chk("tgl_d1",  {24'd0, data_out}, 32'hD1);
    addr = 5'd1; #1; chk("rd_set_zero", rd_data, 32'h0);
    addr = 5'd2; #1; chk("rd_clr_zero", rd_data, 32'h0);
    addr = 5'd3; #1; chk("rd_tgl_zero", rd_data, 32'h0);
    addr = 5'd7; #1; chk("rd_7_zero", rd_data, 32'h0);
    wr(5'd0, 32'hFFFF_FF00); chk("data_upper_ignored", {24'd0, data_out}, 32'h0);

    // Five-cycle pulse on bits 0/1.
    wr(5'd4, 32'd5);
    wr(5'd0, 32'd0);
    wr(5'd5, 32'h03);
    chk("pulse_first_status", rd_data, 32'h0005_0001);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("pulse_high", {24'd0, data_out}, 32'h03);
    end
    idle();
    chk("pulse_low", {24'd0, data_out}, 32'h0);
    chk("pulse_status_done", rd_data, 32'h0);

    // Zero length is a no-op.
    wr(5'd4, 32'd0);
    wr(5'd5, 32'h01);
    chk("plen0_noop", rd_data, 32'h0);

    // Single-cycle strobe.
    wr(5'd4, 32'd1);
    wr(5'd5, 32'h01);
    chk("strobe_high", {24'd0, data_out}, 32'h01);
    idle();
    chk("strobe_low", {24'd0, data_out}, 32'h00);

    // Second PULSE while active is ignored.
    wr(5'd4, 32'd3);
    wr(5'd5, 32'h01);
    wr(5'd5, 32'h04);
    chk("no_retrigger", {24'd0, data_out}, 32'h01);
    idle();
    idle();
    chk("retrigger_end", {24'd0, data_out}, 32'h00);

    // Register write on the expiry edge.
    wr(5'd4, 32'd4);
    wr(5'd5, 32'h01);
    idle(); idle(); idle();
    wr(5'd0, 32'hFF);
    chk("collision", {24'd0, data_out}, 32'hFE);

    // Reset in the middle of a long pulse.
    wr(5'd4, 32'd100);
    wr(5'd5, 32'h80);
    for (int i = 0; i < 9; i++) idle();
    reset = 1'b0;
    idle();
    idle();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    chk("rst_mid_data", {24'd0, data_out}, 32'h0);
    chk("rst_mid_status", rd_data, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      a   = (sel > 7) ? 5'($urandom_range(8, 31)) : 5'(sel);
      d   = (a == 5'd4) ? 32'($urandom_range(0, 6)) : $urandom;
      reset = ($urandom_range(0, 80) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, a, d);
    end
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
